// File: rtl/chess_pkg.sv
// Shared definitions for the per-piece move validators.
// Exports the slider mode encoding, the empty-square value, the piece
// colour values and the slider FSM state type.
package chess_pkg;

  typedef enum logic [1:0] {
    MODE_ROOK   = 2'b00,
    MODE_BISHOP = 2'b01,
    MODE_QUEEN  = 2'b10,
    MODE_RSVD   = 2'b11
  } slider_mode_e;

  localparam int unsigned PIECE_EMPTY = 0;

  localparam logic COLOUR_WHITE = 1'b0;
  localparam logic COLOUR_BLACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    GEOM,
    ISSUE,
    WAIT,
    EVAL,
    DONE
  } slider_state_e;

endpackage

// File: rtl/validator_slider_if.sv
// Request/response and board-read bundle between the move-validation
// controller (master) and the slider validator (slave).
//   start_validation, mode, player_colour, piece_x/y, move_x/y : request
//   slider_complete, slider_valid                             : response
//   validate_x/y (address) / piece_read (data)                : board read
interface validator_slider_if #(
  parameter int unsigned COORD_W = 3,
  parameter int unsigned PIECE_W = 4
);
  logic               start_validation;
  logic [1:0]         mode;
  logic               player_colour;
  logic [COORD_W-1:0] piece_x;
  logic [COORD_W-1:0] piece_y;
  logic [COORD_W-1:0] move_x;
  logic [COORD_W-1:0] move_y;
  logic [PIECE_W-1:0] piece_read;
  logic [COORD_W-1:0] validate_x;
  logic [COORD_W-1:0] validate_y;
  logic               slider_complete;
  logic               slider_valid;

  modport master (
    output start_validation, mode, player_colour,
    output piece_x, piece_y, move_x, move_y,
    output piece_read,
    input  validate_x, validate_y,
    input  slider_complete, slider_valid
  );

  modport slave (
    input  start_validation, mode, player_colour,
    input  piece_x, piece_y, move_x, move_y,
    input  piece_read,
    output validate_x, validate_y,
    output slider_complete, slider_valid
  );
endinterface

// File: rtl/validator_slider_geometry.sv
// Combinational geometry check for sliding pieces.
//   src_x/y, dst_x/y : source and destination squares
//   mode             : rook / bishop / queen / reserved
//   geom_ok          : move shape is legal for the mode and on the board
//   sx, sy           : per-step direction, -1/0/+1
//   d                : path length, max(|dx|, |dy|)
module slider_geometry
  import chess_pkg::*;
#(
  parameter int unsigned COORD_W = 3,
  parameter int unsigned BOARD_N = 8
) (
  input  logic [COORD_W-1:0] src_x,
  input  logic [COORD_W-1:0] src_y,
  input  logic [COORD_W-1:0] dst_x,
  input  logic [COORD_W-1:0] dst_y,
  input  slider_mode_e       mode,
  output logic               geom_ok,
  output logic signed [1:0]  sx,
  output logic signed [1:0]  sy,
  output logic [COORD_W-1:0] d
);
  // One extra bit so BOARD_N == 2**COORD_W is representable.
  localparam logic [COORD_W:0] LIMIT = (COORD_W+1)'(BOARD_N);

  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;
  logic               in_range;
  logic               rook_ok;
  logic               bishop_ok;
  logic               mode_ok;

  always_comb begin
    dx = (dst_x >= src_x) ? dst_x - src_x : src_x - dst_x;
    dy = (dst_y >= src_y) ? dst_y - src_y : src_y - dst_y;

    in_range = ({1'b0, src_x} < LIMIT) && ({1'b0, src_y} < LIMIT) &&
               ({1'b0, dst_x} < LIMIT) && ({1'b0, dst_y} < LIMIT);

    rook_ok   = (dx == '0) != (dy == '0);
    bishop_ok = (dx == dy) && (dx != '0);

    mode_ok = 1'b0;
    case (mode)
      MODE_ROOK:   mode_ok = rook_ok;
      MODE_BISHOP: mode_ok = bishop_ok;
      MODE_QUEEN:  mode_ok = rook_ok || bishop_ok;
      default:     mode_ok = 1'b0;
    endcase

    geom_ok = in_range && mode_ok && !((dx == '0) && (dy == '0));

    sx = (dst_x > src_x) ? 2'sd1 : ((dst_x < src_x) ? -2'sd1 : 2'sd0);
    sy = (dst_y > src_y) ? 2'sd1 : ((dst_y < src_y) ? -2'sd1 : 2'sd0);
    d  = (dx > dy) ? dx : dy;
  end
endmodule

// File: rtl/validator_slider.sv
// Sequential move validator for rook, bishop and queen.
// Checks geometry, walks every intermediate square through the board read
// port, then checks the destination is empty or holds an enemy piece.
//   clk   : system clock
//   reset : asynchronous, active-low
//   bus   : request/response handshake and board read port (slave side)
module validator_slider
  import chess_pkg::*;
#(
  parameter int unsigned COORD_W    = 3,
  parameter int unsigned BOARD_N    = 8,
  parameter int unsigned PIECE_W    = 4,
  parameter int unsigned COLOUR_BIT = 3,
  parameter int unsigned READ_LAT   = 1
) (
  input logic                clk,
  input logic                reset,
  validator_slider_if.slave  bus
);
  localparam int unsigned     WAIT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((READ_LAT > 1) ? READ_LAT - 2 : 0);

  slider_state_e      state_q, state_d;
  slider_mode_e       mode_q, mode_d;
  logic               colour_q, colour_d;
  logic [COORD_W-1:0] src_x_q, src_x_d, src_y_q, src_y_d;
  logic [COORD_W-1:0] dst_x_q, dst_x_d, dst_y_q, dst_y_d;
  logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [COORD_W-1:0] steps_q, steps_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               result_q, result_d;
  logic               complete_q, complete_d;
  logic               valid_q, valid_d;

  logic               geom_ok;
  logic signed [1:0]  sx, sy;
  logic [COORD_W-1:0] d;
  logic               sq_empty;

  slider_geometry #(
    .COORD_W (COORD_W),
    .BOARD_N (BOARD_N)
  ) u_geometry (
    .src_x   (src_x_q),
    .src_y   (src_y_q),
    .dst_x   (dst_x_q),
    .dst_y   (dst_y_q),
    .mode    (mode_q),
    .geom_ok (geom_ok),
    .sx      (sx),
    .sy      (sy),
    .d       (d)
  );

  // Sum in COORD_W+1 bits and drop the carry; both path ends are range
  // checked so the cursor never actually wraps.
  function automatic logic [COORD_W-1:0] step(input logic [COORD_W-1:0] c,
                                               input logic signed [1:0]  s);
    return COORD_W'({1'b0, c} + {{(COORD_W-1){s[1]}}, s});
  endfunction

  assign sq_empty = (bus.piece_read == PIECE_W'(PIECE_EMPTY));

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    colour_d   = colour_q;
    src_x_d    = src_x_q;
    src_y_d    = src_y_q;
    dst_x_d    = dst_x_q;
    dst_y_d    = dst_y_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    steps_d    = steps_q;
    wait_d     = wait_q;
    result_d   = result_q;
    complete_d = 1'b0;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_validation) begin
          mode_d   = slider_mode_e'(bus.mode);
          colour_d = bus.player_colour;
          src_x_d  = bus.piece_x;
          src_y_d  = bus.piece_y;
          dst_x_d  = bus.move_x;
          dst_y_d  = bus.move_y;
          state_d  = GEOM;
        end
      end
      GEOM: begin
        if (!bus.start_validation) begin
          state_d = IDLE;
        end else if (!geom_ok) begin
          result_d = 1'b0;
          state_d  = DONE;
        end else begin
          cur_x_d = step(src_x_q, sx);
          cur_y_d = step(src_y_q, sy);
          steps_d = d;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.start_validation) begin
          state_d = IDLE;
        end else begin
          wait_d  = '0;
          state_d = (READ_LAT > 1) ? WAIT : EVAL;
        end
      end
      WAIT: begin
        if (!bus.start_validation) begin
          state_d = IDLE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = EVAL;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      EVAL: begin
        // steps_q counts squares still to visit, so 1 means the cursor
        // is sitting on the destination.
        if (!bus.start_validation) begin
          state_d = IDLE;
        end else if (steps_q == COORD_W'(1)) begin
          result_d = sq_empty || (bus.piece_read[COLOUR_BIT] != colour_q);
          state_d  = DONE;
        end else if (!sq_empty) begin
          result_d = 1'b0;
          state_d  = DONE;
        end else begin
          cur_x_d = step(cur_x_q, sx);
          cur_y_d = step(cur_y_q, sy);
          steps_d = steps_q - 1'b1;
          state_d = ISSUE;
        end
      end
      DONE: begin
        if (!bus.start_validation) begin
          state_d = IDLE;
        end else begin
          complete_d = 1'b1;
          valid_d    = result_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mode_q     <= MODE_ROOK;
      colour_q   <= 1'b0;
      src_x_q    <= '0;
      src_y_q    <= '0;
      dst_x_q    <= '0;
      dst_y_q    <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      steps_q    <= '0;
      wait_q     <= '0;
      result_q   <= 1'b0;
      complete_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      colour_q   <= colour_d;
      src_x_q    <= src_x_d;
      src_y_q    <= src_y_d;
      dst_x_q    <= dst_x_d;
      dst_y_q    <= dst_y_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      steps_q    <= steps_d;
      wait_q     <= wait_d;
      result_q   <= result_d;
      complete_q <= complete_d;
      valid_q    <= valid_d;
    end
  end

  // The cursor register doubles as the read address, so it holds its last
  // value whenever no walk is in progress.
  assign bus.validate_x      = cur_x_q;
  assign bus.validate_y      = cur_y_q;
  assign bus.slider_complete = complete_q;
  assign bus.slider_valid    = valid_q;
endmodule
